lcd_char_scanner: RTL and testbench
===================================

# lcd_char_scanner

Character-LCD front end for the watch display path. It scans the 32-position character index (two lines of 16) that the mode display blocks decode, latches each returned ASCII byte, and drives an HD44780-compatible 8-bit write-only bus. The block initialises the panel after reset and then refreshes both lines continuously. It is timed by a slow strobe `en_tick` from the shared clock-enable generator.

## Interface
- `POWERUP_TICKS`, 50, number of `en_tick` strobes to wait after reset before the first bus transfer.
- `CLR_WAIT`, 2, number of extra `en_tick` strobes to wait after the clear-display command completes.

- `clk` in 1 system clock.
- `rst` in 1 reset, asynchronous, active-low.
- `en_tick` in 1 single-clk strobe. Consecutive strobes are at least 3 clk apart.
- `char_in` in 8 ASCII byte from the mode block for the current `index`. It is registered at the source, so it is valid 1 clk after `index` changes.
- `index` out 5 character position being requested: 0–15 for line 1, 16–31 for line 2.
- `lcd_e` out 1 LCD enable strobe.
- `lcd_rs` out 1 register select: 0 = command, 1 = data.
- `lcd_rw` out 1 read/write select. Constant 0 (write only).
- `lcd_data` out 8 LCD data bus.
- `frame_done` out 1 one-clk pulse when the write of character 31 completes.

## Operation
- Reset values: `index`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00, `frame_done`=0. The state returns to PWR_WAIT and the tick and phase counters clear.
- All state advances only on clk edges where `en_tick`=1. The outputs hold between strobes.
- Each bus transfer takes exactly 3 strobes:
  - ph0 (setup): load `lcd_rs` and `lcd_data`; `lcd_e`=0.
  - ph1: `lcd_e`=1.
  - ph2 (hold): `lcd_e`=0; the sequence pointer advances.
- State sequence:
  - PWR_WAIT: consume `POWERUP_TICKS` strobes.
  - INIT: command transfers 8'h38, 8'h0C, 8'h06, 8'h01, in that order, with `lcd_rs`=0.
  - CLR_HOLD: consume `CLR_WAIT` strobes.
  - ADDR1: command 8'h80.
  - LINE1: 16 data transfers, `lcd_rs`=1.
  - ADDR2: command 8'hC0.
  - LINE2: 16 data transfers.
  - After LINE2, return to ADDR1 and repeat indefinitely. INIT and PWR_WAIT are never re-entered without a reset.
- `index` behaviour:
  - Held at 0 through PWR_WAIT, INIT, CLR_HOLD and ADDR1.
  - During a data transfer, the data ph0 loads `lcd_data` <= `char_in`.
  - Incremented by 1 at the ph2 of each data transfer. After character 31 it wraps to 0 (5-bit modulo arithmetic).
  - Holds 16 throughout ADDR2.
- `char_in` sampling: `char_in` is sampled only at data ph0. Because of the minimum strobe spacing, `index` has been stable for at least 3 clk at that point. Changes to `char_in` at any other time do not affect the bus.
- `frame_done`: asserted for exactly 1 clk, on the clk of the ph2 strobe of character 31. It is deasserted on the next clk regardless of `en_tick`.
- Reset mid-operation: if asserted while `lcd_e`=1, `lcd_e` drops immediately (asynchronous). The sequence restarts from PWR_WAIT; there is no partial resumption.

## Timing
- Strobes are numbered from 1 after reset release, with defaults P=50, C=2.
- Initialisation:
  - 8'h38: ph0 on strobe 51, ph1 on 52, ph2 on 53.
  - 8'h0C: 54–56.
  - 8'h06: 57–59.
  - 8'h01: 60–62.
  - CLR_HOLD: strobes 63–64.
  - General form: the ph0 of 8'h38 falls on strobe P+1, and the first 8'h80 ph0 falls on strobe P+13+C.
- First frame:
  - ADDR1 8'h80: ph0 on strobe 65.
  - Character k (0–15): ph0 on strobe 68+3k.
  - ADDR2 8'hC0: ph0 on strobe 116.
  - Character k (16–31): ph0 on strobe 119+3(k−16).
  - Character 31: ph0 on strobe 164, ph2 (and `frame_done`) on strobe 166.
  - Next 8'h80: ph0 on strobe 167.
- Frame period: 34 transfers × 3 = 102 strobes.
- `lcd_e` high width: exactly one strobe interval.
- Around the `lcd_e` high pulse, `lcd_data` and `lcd_rs` are stable for at least one strobe interval before and after.

## Test plan
- Reset: hold `rst`=0 with `en_tick` running. Expect all outputs at their reset values, no `lcd_e` pulse, and `index`=0. After release, expect no `lcd_e` rise before strobe 52.
- Init sequence: capture `lcd_data` and `lcd_rs` on each `lcd_e` falling edge. Expect 38,0C,06,01 with rs=0, then 80 with rs=0. Expect the `lcd_e` rises on strobes 52, 55, 58, 61 and 66.
- Frame content: model `char_in` = 8'h40 + `index`, registered 1 clk after `index`. Captured writes must be 80, 40..4F (rs=1), C0, 50..5F (rs=1). Expect `frame_done` on strobe 166 and 8'h80 again on strobe 167.
- `char_in` isolation: toggle `char_in` to 8'hFF except on data-ph0 clocks. Captured bytes must still match the model; 8'hFF must never appear on the bus.
- Wrap/continuity: run 3 frames. Expect `frame_done` exactly 102 strobes apart, `index` wrapping 31→0, and no re-issue of 38/0C/06/01.
- Mid-transfer reset: assert `rst` on a clk where `lcd_e`=1 during character 20. Expect `lcd_e`=0 immediately. After release, expect the full PWR_WAIT and init sequence again, with timing identical to the first scenario.

Source files
------------

// File: rtl/lcd_char_scanner.sv
// lcd_char_scanner: scans 32 character positions, latches the returned ASCII
// bytes and drives an HD44780-compatible 8-bit write-only bus. It initialises
// the panel after reset, then refreshes both 16-character lines forever.
//
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   en_tick         slow single-clk strobe; all sequencing advances only on it
//   char_in[7:0]    ASCII byte for the current index (registered at source)
//   index[4:0]      requested character position (0-15 line 1, 16-31 line 2)
//   lcd_e/rs/rw     LCD enable, register select (1 = data), read/write (tied 0)
//   lcd_data[7:0]   LCD data bus
//   frame_done      one-clk pulse when the write of character 31 completes
module lcd_char_scanner #(
  parameter int POWERUP_TICKS = 50,
  parameter int CLR_WAIT      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tick,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    CLR_HOLD,
    ADDR1,
    LINE1,
    ADDR2,
    LINE2
  } state_t;

  // Every bus transfer is setup / enable-high / hold, one strobe each.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_t;

  localparam int                CNT_W    = 16;
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_TICKS - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);

  localparam logic [7:0] CMD_ADDR1 = 8'h80;
  localparam logic [7:0] CMD_ADDR2 = 8'hC0;

  state_t           r_state;
  phase_t           r_phase;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0]       r_init_ptr;
  logic [4:0]       r_index;
  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic [7:0]       r_lcd_data;
  logic             r_frame_done;

  state_t           w_state_nxt;
  phase_t           w_phase_nxt;
  logic [CNT_W-1:0] w_tick_nxt;
  logic [1:0]       w_init_ptr_nxt;
  logic [4:0]       w_index_nxt;
  logic             w_lcd_e_nxt;
  logic             w_lcd_rs_nxt;
  logic [7:0]       w_lcd_data_nxt;
  logic             w_frame_done_nxt;

  // Content of the transfer the current state would put on the bus.
  logic             w_xfer;
  logic             w_xfer_rs;
  logic [7:0]       w_xfer_dat;

  always_comb begin
    w_xfer     = 1'b0;
    w_xfer_rs  = 1'b0;
    w_xfer_dat = 8'h00;
    case (r_state)
      INIT: begin
        w_xfer = 1'b1;
        case (r_init_ptr)
          2'd0:    w_xfer_dat = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
          2'd1:    w_xfer_dat = 8'h0C;  // display on, cursor off
          2'd2:    w_xfer_dat = 8'h06;  // auto-increment, no shift
          default: w_xfer_dat = 8'h01;  // clear display
        endcase
      end
      ADDR1: begin
        w_xfer     = 1'b1;
        w_xfer_dat = CMD_ADDR1;
      end
      ADDR2: begin
        w_xfer     = 1'b1;
        w_xfer_dat = CMD_ADDR2;
      end
      LINE1, LINE2: begin
        w_xfer     = 1'b1;
        w_xfer_rs  = 1'b1;
        w_xfer_dat = char_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_tick_nxt       = r_tick_cnt;
    w_init_ptr_nxt   = r_init_ptr;
    w_index_nxt      = r_index;
    w_lcd_e_nxt      = r_lcd_e;
    w_lcd_rs_nxt     = r_lcd_rs;
    w_lcd_data_nxt   = r_lcd_data;
    w_frame_done_nxt = 1'b0;

    if (en_tick) begin
      if (w_xfer) begin
        case (r_phase)
          PH_SETUP: begin
            // char_in is only ever sampled here; index has been stable since
            // the previous hold phase, so the source register has caught up.
            w_lcd_e_nxt    = 1'b0;
            w_lcd_rs_nxt   = w_xfer_rs;
            w_lcd_data_nxt = w_xfer_dat;
            w_phase_nxt    = PH_PULSE;
          end
          PH_PULSE: begin
            w_lcd_e_nxt = 1'b1;
            w_phase_nxt = PH_HOLD;
          end
          default: begin
            w_lcd_e_nxt = 1'b0;
            w_phase_nxt = PH_SETUP;
            case (r_state)
              INIT: begin
                if (r_init_ptr == 2'd3) begin
                  w_init_ptr_nxt = 2'd0;
                  w_state_nxt    = (CLR_WAIT == 0) ? ADDR1 : CLR_HOLD;
                end else begin
                  w_init_ptr_nxt = r_init_ptr + 2'd1;
                end
              end
              ADDR1: w_state_nxt = LINE1;
              ADDR2: w_state_nxt = LINE2;
              LINE1: begin
                w_index_nxt = r_index + 5'd1;
                if (r_index == 5'd15) w_state_nxt = ADDR2;
              end
              LINE2: begin
                // 31 + 1 wraps to 0 in 5 bits, ready for the next frame.
                w_index_nxt = r_index + 5'd1;
                if (r_index == 5'd31) begin
                  w_frame_done_nxt = 1'b1;
                  w_state_nxt      = ADDR1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end else begin
        case (r_state)
          PWR_WAIT: begin
            if (r_tick_cnt == PWR_LAST) begin
              w_tick_nxt  = '0;
              w_state_nxt = INIT;
            end else begin
              w_tick_nxt = r_tick_cnt + CNT_W'(1);
            end
          end
          CLR_HOLD: begin
            if (r_tick_cnt == CLR_LAST) begin
              w_tick_nxt  = '0;
              w_state_nxt = ADDR1;
            end else begin
              w_tick_nxt = r_tick_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= PWR_WAIT;
      r_phase      <= PH_SETUP;
      r_tick_cnt   <= '0;
      r_init_ptr   <= 2'd0;
      r_index      <= 5'd0;
      r_lcd_e      <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_init_ptr   <= w_init_ptr_nxt;
      r_index      <= w_index_nxt;
      r_lcd_e      <= w_lcd_e_nxt;
      r_lcd_rs     <= w_lcd_rs_nxt;
      r_lcd_data   <= w_lcd_data_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign index      = r_index;
  assign lcd_e      = r_lcd_e;
  assign lcd_rs     = r_lcd_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = r_lcd_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_char_scanner.sv
// tb_lcd_char_scanner: drives en_tick every 4 clk and a char_in source model
// (8'h40 + index, one clk behind index), and scores every LCD write and
// frame_done pulse against expected strobe numbers and contents.
module tb_lcd_char_scanner;

  localparam int P = 50;
  localparam int C = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_tick;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       frame_done;

  always #5 clk = ~clk;

  lcd_char_scanner #(
    .POWERUP_TICKS(P),
    .CLR_WAIT     (C)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en_tick   (en_tick),
    .char_in   (char_in),
    .index     (index),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .frame_done(frame_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    int         strobe;
    int         idx;
    logic       rs;
    logic [7:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  fd_q[$];

  // Strobes numbered from 1 after reset release.
  int strobe_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) strobe_cnt <= 0;
    else if (en_tick) strobe_cnt <= strobe_cnt + 1;
  end

  // en_tick and char_in source; in isolation mode char_in is 8'hFF on every
  // clk that is not a strobe.
  bit         iso = 1'b0;
  logic [4:0] idx_d;
  int         div;
  initial begin
    en_tick = 1'b0;
    char_in = 8'h00;
    idx_d   = 5'd0;
    div     = 0;
    forever begin
      @(negedge clk);
      en_tick = (div == 3);
      div     = (div + 1) % 4;
      char_in = (iso && !en_tick) ? 8'hFF : 8'h40 + {3'b000, idx_d};
      idx_d   = index;
    end
  end

  // Monitor
  bit   mon_en = 1'b0;
  logic prev_e = 1'b0;
  logic prev_fd = 1'b0;
  wr_t  cur;
  int   rise_cnt = 0;
  int   e_in_reset = 0;
  int   fd_seen = 0;
  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (lcd_e && !prev_e) begin
          rise_cnt++;
          check_eq("sb_avail", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_eq("rise_strobe", strobe_cnt, cur.strobe);
            check_eq("rise_index", int'(index), cur.idx);
            check_eq("rise_rs", int'(lcd_rs), int'(cur.rs));
            check_eq("rise_data", int'(lcd_data), int'(cur.dat));
            check_eq("rw", int'(lcd_rw), 0);
          end
        end
        if (!lcd_e && prev_e) begin
          check_eq("fall_rs", int'(lcd_rs), int'(cur.rs));
          check_eq("fall_data", int'(lcd_data), int'(cur.dat));
        end
        if (frame_done) begin
          check_eq("fd_width", int'(prev_fd), 0);
          check_eq("fd_avail", int'(fd_q.size() > 0), 1);
          if (fd_q.size() > 0) check_eq("fd_strobe", strobe_cnt, fd_q.pop_front());
          check_eq("fd_index_wrap", int'(index), 0);
          fd_seen++;
        end
      end else if (!rst && lcd_e) begin
        e_in_reset++;
      end
      prev_e  = lcd_e;
      prev_fd = frame_done;
    end
  end

  task automatic push_init();
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{strobe: P + 2 + 3 * i, idx: 0, rs: 1'b0, dat: cmds[i]});
  endtask

  // Pushes the first ntr transfers of frame f (34 transfers per frame).
  task automatic push_frame(input int f, input int ntr);
    int base;
    int k;
    base = P + C + 14 + 102 * f;
    for (int t = 0; t < ntr; t++) begin
      if (t == 0)
        exp_q.push_back('{strobe: base, idx: 0, rs: 1'b0, dat: 8'h80});
      else if (t == 17)
        exp_q.push_back('{strobe: base + 3 * t, idx: 16, rs: 1'b0, dat: 8'hC0});
      else begin
        k = (t < 17) ? t - 1 : t - 2;
        exp_q.push_back('{strobe: base + 3 * t, idx: k, rs: 1'b1,
                          dat: 8'(8'h40 + k)});
      end
    end
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (fd_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, int'(fd_seen >= n), 1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_index"}, int'(index), 0);
    check_eq({pfx, "_e"}, int'(lcd_e), 0);
    check_eq({pfx, "_rs"}, int'(lcd_rs), 0);
    check_eq({pfx, "_rw"}, int'(lcd_rw), 0);
    check_eq({pfx, "_data"}, int'(lcd_data), 0);
    check_eq({pfx, "_fd"}, int'(frame_done), 0);
  endtask

  initial begin
    int  k;
    bit  found;

    // Reset held with strobes running.
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_reset_vals("rst1");
    check_eq("rst1_no_e", e_in_reset, 0);

    push_init();
    for (int f = 0; f < 3; f++) begin
      push_frame(f, 34);
      fd_q.push_back(P + C + 114 + 102 * f);
    end
    push_frame(3, 23);  // up to and including character 20
    mon_en = 1'b1;
    rst    = 1'b1;

    // No enable pulse before strobe 52.
    k = 0;
    while (strobe_cnt < 51 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_s51", int'(strobe_cnt >= 51), 1);
    check_eq("no_e_before52", rise_cnt, 0);

    wait_fd(1, 1000, "frame1_done");
    iso = 1'b1;
    wait_fd(3, 1200, "frame3_done");

    // Reset while lcd_e is high during character 20.
    found = 1'b0;
    k = 0;
    while (!found && k < 600) begin
      @(negedge clk);
      k++;
      found = lcd_e && (index == 5'd20);
    end
    check_eq("char20_e_high", int'(found), 1);
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_eq("async_e_drop", int'(lcd_e), 0);
    check_eq("sb_drained_pre_rst", exp_q.size(), 0);
    iso = 1'b0;
    repeat (20) @(negedge clk);
    check_reset_vals("rst2");

    // Restart must match the first scenario exactly.
    fd_seen = 0;
    push_init();
    push_frame(0, 34);
    push_frame(1, 1);
    fd_q.push_back(P + C + 114);
    mon_en = 1'b1;
    rst    = 1'b1;
    wait_fd(1, 1000, "restart_frame_done");
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check_eq("sb_final", exp_q.size(), 0);
    check_eq("fd_final", fd_q.size(), 0);
    check_eq("no_e_in_reset", e_in_reset, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
